// File: rtl/acc_cpu_sequencer_pkg.sv
// Shared constants for the accumulator CPU sequencer: opcodes, FSM states,
// and the ALU / ACC control encodings driven into the datapath.
package acc_cpu_sequencer_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_CSL  = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_CLA  = 4'b0101;
    localparam logic [3:0] OP_COM  = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JZ   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CSL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b110;

    localparam logic [1:0] ACC_PASS = 2'b00;
    localparam logic [1:0] ACC_CLR  = 2'b01;
    localparam logic [1:0] ACC_COM  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_ADDI, OP_CSL, OP_SHR, OP_SW, OP_CLA,
            OP_COM, OP_LW, OP_JMP, OP_JZ, OP_HALT: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/acc_cpu_sequencer_decode.sv
// Combinational opcode classifier: datapath control codes and the instruction
// class flags the sequencer FSM branches on.
module acc_seq_decode
    import acc_cpu_sequencer_pkg::*;
(
    input  logic [3:0] op,
    output logic [2:0] alu_ctl,
    output logic [1:0] acc_ctl,
    output logic       acc_ld_ok,
    output logic       is_mem,
    output logic       is_branch,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        alu_ctl    = ALU_ADD;
        acc_ctl    = ACC_PASS;
        acc_ld_ok  = 1'b0;
        is_mem     = 1'b0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = !is_legal_op(op);
        case (op)
            OP_ADD, OP_ADDI: acc_ld_ok = 1'b1;
            OP_CSL: begin
                alu_ctl   = ALU_CSL;
                acc_ld_ok = 1'b1;
            end
            OP_SHR: begin
                alu_ctl   = ALU_SHR;
                acc_ld_ok = 1'b1;
            end
            OP_CLA: begin
                acc_ctl   = ACC_CLR;
                acc_ld_ok = 1'b1;
            end
            OP_COM: begin
                acc_ctl   = ACC_COM;
                acc_ld_ok = 1'b1;
            end
            OP_SW, OP_LW:   is_mem    = 1'b1;
            OP_JMP, OP_JZ:  is_branch = 1'b1;
            OP_HALT:        is_halt   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC|MEM/WB controller for the accumulator CPU,
// with ROM wait-state handshakes, an ack timeout and a retired-instruction count.
module acc_cpu_sequencer
    import acc_cpu_sequencer_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             acc_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic [2:0]       alu_ctl,
    output logic [1:0]       acc_ctl,
    output logic             acc_ld,
    output logic             acc_src_mem,
    output logic             dmem_req,
    output logic             data_rom_write_en,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic [3:0]        op_q_reg, op_q_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  retired_cnt_reg, retired_cnt_next;

    logic [3:0] dec_op;
    logic [2:0] dec_alu_ctl;
    logic [1:0] dec_acc_ctl;
    logic       dec_acc_ld_ok;
    logic       dec_is_mem;
    logic       dec_is_branch;
    logic       dec_is_halt;
    logic       dec_is_illegal;
    logic       wait_expired;

    // DECODE classifies the live IR opcode; later states use the registered copy.
    assign dec_op = (state_reg == ST_DECODE) ? opcode : op_q_reg;

    acc_seq_decode u_decode (
        .op         (dec_op),
        .alu_ctl    (dec_alu_ctl),
        .acc_ctl    (dec_acc_ctl),
        .acc_ld_ok  (dec_acc_ld_ok),
        .is_mem     (dec_is_mem),
        .is_branch  (dec_is_branch),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    assign wait_expired = (wait_cnt_reg == WAIT_W'(TIMEOUT));
    assign retired_cnt  = retired_cnt_reg;

    always_comb begin
        state_next        = state_reg;
        op_q_next         = op_q_reg;
        wait_cnt_next     = wait_cnt_reg;
        retired_cnt_next  = retired_cnt_reg;
        imem_req          = 1'b0;
        ir_ld             = 1'b0;
        pc_inc            = 1'b0;
        pc_ld             = 1'b0;
        alu_ctl           = ALU_ADD;
        acc_ctl           = ACC_PASS;
        acc_ld            = 1'b0;
        acc_src_mem       = 1'b0;
        dmem_req          = 1'b0;
        data_rom_write_en = 1'b0;
        halted            = 1'b0;
        illegal_op        = 1'b0;
        bus_err           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                halted = 1'b1;
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // A late ack on the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_ld      = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    bus_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                op_q_next = opcode;
                if (dec_is_illegal) begin
                    illegal_op = 1'b1;
                    state_next = ST_EXEC;
                end else if (dec_is_mem) begin
                    state_next = ST_MEM;
                end else if (dec_is_halt) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_ctl    = dec_alu_ctl;
                acc_ctl    = dec_acc_ctl;
                acc_ld     = dec_acc_ld_ok;
                pc_ld      = dec_is_branch && ((op_q_reg != OP_JZ) || acc_zero);
                state_next = ST_WB;
            end
            ST_MEM: begin
                dmem_req          = 1'b1;
                data_rom_write_en = (op_q_reg == OP_SW);
                if (op_q_reg == OP_LW) begin
                    acc_src_mem = 1'b1;
                    acc_ld      = dmem_ack;
                end
                if (dmem_ack) begin
                    state_next = ST_WB;
                end else if (wait_expired) begin
                    bus_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            ST_WB: begin
                retired_cnt_next = retired_cnt_reg + CNT_W'(1);
                state_next       = run ? ST_FETCH : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next != state_reg) wait_cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            op_q_reg        <= 4'b0000;
            wait_cnt_reg    <= '0;
            retired_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            op_q_reg        <= op_q_next;
            wait_cnt_reg    <= wait_cnt_next;
            retired_cnt_reg <= retired_cnt_next;
        end
    end

endmodule
